// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: shared counter encodings, FSM states and counter update helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table: predictor storage; fetch and execute lookup ports, one sync write port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_ridx_f,
  output logic             o_valid_f,
  output logic [TAG_W-1:0] o_tag_f,
  output logic [31:0]      o_target_f,
  output logic [1:0]       o_ctr_f,
  input  logic [IDX_W-1:0] i_ridx_e,
  output logic             o_valid_e,
  output logic [TAG_W-1:0] o_tag_e,
  output logic [31:0]      o_target_e,
  output logic [1:0]       o_ctr_e,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic             i_wvalid,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic [31:0]      i_wtarget,
  input  logic [1:0]       i_wctr
);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  // No reset here: the controller's INIT sweep establishes the contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_valid[i_widx]  <= i_wvalid;
      r_tag[i_widx]    <= i_wtag;
      r_target[i_widx] <= i_wtarget;
      r_ctr[i_widx]    <= i_wctr;
    end
  end

  assign o_valid_f  = r_valid[i_ridx_f];
  assign o_tag_f    = r_tag[i_ridx_f];
  assign o_target_f = r_target[i_ridx_f];
  assign o_ctr_f    = r_ctr[i_ridx_f];

  assign o_valid_e  = r_valid[i_ridx_e];
  assign o_tag_e    = r_tag[i_ridx_e];
  assign o_target_e = r_target[i_ridx_e];
  assign o_ctr_e    = r_ctr[i_ridx_e];

endmodule

`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pred_ctrl: fetch next-PC prediction, branch resolution and table update.
// Optional macro BP_STATS_EN adds branch/mispredict counters. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  output logic [31:0] next_pc_f,
  output logic        init_busy,
  input  logic        branch_e,
  input  logic [31:0] pc_e,
  input  logic        taken_e,
  input  logic [31:0] target_e,
  input  logic        pred_taken_e,
  input  logic [31:0] pred_target_e,
  output logic        flush_o,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  bp_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_init_ptr, w_ptr_nxt;

  logic [IDX_W-1:0] w_idx_f, w_idx_e;
  logic [TAG_W-1:0] w_pctag_f, w_pctag_e;
  logic             w_valid_f, w_valid_e;
  logic [TAG_W-1:0] w_tag_f, w_tag_e;
  logic [31:0]      w_target_f, w_target_e;
  logic [1:0]       w_ctr_f, w_ctr_e;

  logic             w_we, w_wvalid;
  logic [IDX_W-1:0] w_widx;
  logic [TAG_W-1:0] w_wtag;
  logic [31:0]      w_wtarget;
  logic [1:0]       w_wctr;

  logic w_run, w_hit_f, w_hit_e, w_resolve, w_mispredict;
  logic w_unused;

  assign w_idx_f   = pc_f[IDX_W+1:2];
  assign w_idx_e   = pc_e[IDX_W+1:2];
  assign w_pctag_f = pc_f[31:IDX_W+2];
  assign w_pctag_e = pc_e[31:IDX_W+2];
  assign w_unused  = ^{pc_f[1:0], pc_e[1:0]};

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk        (clk),
    .i_ridx_f   (w_idx_f),
    .o_valid_f  (w_valid_f),
    .o_tag_f    (w_tag_f),
    .o_target_f (w_target_f),
    .o_ctr_f    (w_ctr_f),
    .i_ridx_e   (w_idx_e),
    .o_valid_e  (w_valid_e),
    .o_tag_e    (w_tag_e),
    .o_target_e (w_target_e),
    .o_ctr_e    (w_ctr_e),
    .i_we       (w_we),
    .i_widx     (w_widx),
    .i_wvalid   (w_wvalid),
    .i_wtag     (w_wtag),
    .i_wtarget  (w_wtarget),
    .i_wctr     (w_wctr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_ptr_nxt;
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_hit_f   = w_run && w_valid_f && (w_tag_f == w_pctag_f);
  assign w_hit_e   = w_valid_e && (w_tag_e == w_pctag_e);
  assign w_resolve = w_run && branch_e;
  assign w_mispredict = (taken_e != pred_taken_e) ||
                        (taken_e && (target_e != pred_target_e));

  assign init_busy     = !w_run;
  assign pred_taken_f  = w_hit_f && w_ctr_f[1];
  assign pred_target_f = w_hit_f ? w_target_f : 32'd0;
  assign flush_o       = w_resolve && w_mispredict;
  assign redirect_pc   = w_resolve ? (taken_e ? target_e : pc_e + 32'd4) : 32'd0;
  assign next_pc_f     = flush_o      ? redirect_pc   :
                         pred_taken_f ? pred_target_f : pc_f + 32'd4;

  // Single write port: INIT sweep owns it, afterwards execute-stage updates do.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_init_ptr;
    w_we        = 1'b0;
    w_widx      = r_init_ptr;
    w_wvalid    = 1'b0;
    w_wtag      = '0;
    w_wtarget   = 32'd0;
    w_wctr      = CTR_WNT;
    case (r_state)
      ST_INIT: begin
        w_we      = 1'b1;
        w_ptr_nxt = r_init_ptr + IDX_W'(1);
        if (r_init_ptr == IDX_W'(ENTRIES - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (branch_e) begin
          w_widx    = w_idx_e;
          w_wvalid  = 1'b1;
          w_wtag    = w_pctag_e;
          w_wtarget = target_e;
          if (w_hit_e) begin
            w_we   = 1'b1;
            w_wctr = ctr_next(w_ctr_e, taken_e);
            if (!taken_e) begin
              w_wtarget = w_target_e;
            end
          end else if (taken_e) begin
            w_we   = 1'b1;
            w_wctr = CTR_WT;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br, r_stat_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br  <= 32'd0;
      r_stat_mis <= 32'd0;
    end else begin
      if (w_resolve) r_stat_br  <= r_stat_br + 32'd1;
      if (flush_o)   r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_pred_ctrl: directed + random stimulus against a behavioural predictor model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_pred_ctrl;

  logic        clk, rst;
  logic [31:0] pc_f, pc_e, target_e, pred_target_e;
  logic        branch_e, taken_e, pred_taken_e;
  logic        pred_taken_f, init_busy, flush_o;
  logic [31:0] pred_target_f, next_pc_f, redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_pred_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_f          (pc_f),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .next_pc_f     (next_pc_f),
    .init_busy     (init_busy),
    .branch_e      (branch_e),
    .pc_e          (pc_e),
    .taken_e       (taken_e),
    .target_e      (target_e),
    .pred_taken_e  (pred_taken_e),
    .pred_target_e (pred_target_e),
    .flush_o       (flush_o),
    .redirect_pc   (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one record per table slot, indexed by (pc/4) mod 16.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_nbr, m_nfl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 6));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_nbr = 0;
    m_nfl = 0;
  endtask

  task automatic drive(input logic [31:0] pf, input logic br, input logic [31:0] pe,
                       input logic tk, input logic [31:0] tg, input logic ptk,
                       input logic [31:0] ptg);
    pc_f = pf; branch_e = br; pc_e = pe; taken_e = tk;
    target_e = tg; pred_taken_e = ptk; pred_target_e = ptg;
  endtask

  // Check all outputs for the current inputs at the falling edge, then clock and update model.
  task automatic check_tick();
    bit          ph, eh, mis, pt;
    logic [31:0] ptg, redir, nxt;
    int          fi, ei;
    @(negedge clk);
    fi    = slot(pc_f);
    ph    = m_hit(pc_f);
    pt    = ph && (m_ctr[fi] >= 2);
    ptg   = ph ? m_tgt[fi] : 32'd0;
    mis   = branch_e && ((taken_e != pred_taken_e) || (taken_e && target_e != pred_target_e));
    redir = taken_e ? target_e : pc_e + 32'd4;
    nxt   = mis ? redir : (pt ? ptg : pc_f + 32'd4);
    chk("init_busy", {31'd0, init_busy}, 32'd0);
    chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, pt});
    chk("pred_target_f", pred_target_f, ptg);
    chk("flush_o", {31'd0, flush_o}, {31'd0, mis});
    chk("next_pc_f", next_pc_f, nxt);
    if (branch_e) chk("redirect_pc", redirect_pc, redir);
    ei = slot(pc_e);
    eh = m_hit(pc_e);
    @(posedge clk);
    if (branch_e) begin
      m_nbr++;
      if (mis) m_nfl++;
      if (eh) begin
        if (taken_e) begin
          m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
          m_tgt[ei] = target_e;
        end else begin
          m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
        end
      end else if (taken_e) begin
        m_valid[ei] = 1'b1;
        m_tag[ei]   = pc_e >> 6;
        m_tgt[ei]   = target_e;
        m_ctr[ei]   = 2;
      end
    end
    #1;
  endtask

  // Expect exactly 16 busy cycles from now (called just after a reset release).
  task automatic check_init_sweep(input string name);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({name, "_busy"}, {31'd0, init_busy}, 32'd1);
      chk({name, "_next"}, next_pc_f, 32'h104);
      chk({name, "_pt"}, {31'd0, pred_taken_f}, 32'd0);
      chk({name, "_flush"}, {31'd0, flush_o}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk({name, "_done"}, {31'd0, init_busy}, 32'd0);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  initial begin
    logic [31:0] rp, re, rt;
    logic        rtk, mpt;
    rst = 1'b0;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_pt", {31'd0, pred_taken_f}, 32'd0);
    chk("rst_ptgt", pred_target_f, 32'd0);
    chk("rst_next", next_pc_f, 32'h104);
    chk("rst_redir", redirect_pc, 32'd0);
`ifdef BP_STATS_EN
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
    rst = 1'b1;
    // Execute-side activity during INIT must be ignored.
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    check_init_sweep("init");
    branch_e = 1'b0;

    // Cold miss, taken
    drive(32'h100, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("cold_flush", {31'd0, flush_o}, 32'd1);
    chk("cold_redir", redirect_pc, 32'h80);
    check_tick();
`ifdef BP_STATS_EN
    chk("cold_stat_br", stat_branches, 32'd1);
    chk("cold_stat_mis", stat_mispredicts, 32'd1);
`endif
    drive(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("cold_hit_pt", {31'd0, pred_taken_f}, 32'd1);
    chk("cold_hit_next", next_pc_f, 32'h80);
    check_tick();

    // Saturation up, then two not-taken resolutions
    repeat (3) begin
      drive(32'h100, 1'b1, 32'h20, 1'b1, 32'h80, 1'b1, 32'h80);
      check_tick();
    end
    repeat (2) begin
      drive(32'h100, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h80);
      #1;
      chk("sat_nt_flush", {31'd0, flush_o}, 32'd1);
      chk("sat_nt_redir", redirect_pc, 32'h24);
      check_tick();
    end
    drive(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("sat_wnt_pt", {31'd0, pred_taken_f}, 32'd0);
    chk("sat_wnt_next", next_pc_f, 32'h24);
    check_tick();

    // Climb back to strongly taken, then a target mismatch
    repeat (2) begin
      drive(32'h100, 1'b1, 32'h20, 1'b1, 32'h80, 1'b1, 32'h80);
      check_tick();
    end
    drive(32'h100, 1'b1, 32'h20, 1'b1, 32'hC0, 1'b1, 32'h80);
    #1;
    chk("tgt_flush", {31'd0, flush_o}, 32'd1);
    chk("tgt_redir", redirect_pc, 32'hC0);
    check_tick();
    drive(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("tgt_new", pred_target_f, 32'hC0);
    check_tick();

    // Aliasing: 0x60 shares the slot of 0x20
    drive(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("alias_pt", {31'd0, pred_taken_f}, 32'd0);
    check_tick();
    drive(32'h100, 1'b1, 32'h60, 1'b1, 32'h300, 1'b0, 32'h0);
    check_tick();
    drive(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("alias_evict_pt", {31'd0, pred_taken_f}, 32'd0);
    chk("alias_evict_next", next_pc_f, 32'h24);
    check_tick();

    // PC wrap on both the fall-through and redirect paths
    drive(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    chk("wrap_redir", redirect_pc, 32'd0);
    chk("wrap_next", next_pc_f, 32'd0);
    check_tick();

    // Random traffic; mostly consistent fetch-time predictions so both outcomes occur
    for (int n = 0; n < 300; n++) begin
      re  = rand_pc();
      rtk = 1'($urandom_range(0, 1));
      rt  = 32'($urandom_range(0, 255)) << 2;
      mpt = m_hit(re) && (m_ctr[slot(re)] >= 2);
      rp  = rand_pc();
      if ($urandom_range(0, 3) != 0)
        drive(rp, 1'($urandom_range(0, 3) != 0), re, rtk, rt, mpt,
              m_hit(re) ? m_tgt[slot(re)] : 32'd0);
      else
        drive(rp, 1'b1, re, rtk, rt, 1'($urandom_range(0, 1)), rand_pc());
      check_tick();
    end
`ifdef BP_STATS_EN
    chk("rand_stat_br", stat_branches, 32'(m_nbr));
    chk("rand_stat_mis", stat_mispredicts, 32'(m_nfl));
`endif

    // Reset, abort the sweep after 5 cycles, then a full sweep must follow
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b0;
    #2;
    chk("mid_rst_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b1;
    check_init_sweep("reinit");
    model_clear();
`ifdef BP_STATS_EN
    chk("reinit_stat_br", stat_branches, 32'd0);
    chk("reinit_stat_mis", stat_mispredicts, 32'd0);
`endif
    for (int k = 0; k < 16; k++) begin
      drive(32'(k) << 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
